// File: rtl/strobe_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_fifo_pkg
//  Description : Shared types for the strobe capture FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package strobe_fifo_pkg;

    // Occupancy update selected each cycle from the push/pop pair.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

endpackage : strobe_fifo_pkg
`default_nettype wire

// File: rtl/strobe_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_fifo
//  Description : Captures one-cycle strobes and their data words into a
//                first-word-fall-through FIFO with a valid/ready output.
//                Strobes arriving while full are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module strobe_fifo
    import strobe_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  strobe_in,
    input  logic [WIDTH-1:0]      data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [DROP_BITS-1:0]  drop_count,
    input  logic                  clear_overflow
);

    localparam int                    c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_FULL_COUNT = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DROP_BITS-1:0]  c_DROP_ONE   = DROP_BITS'(1);
    localparam logic [DROP_BITS-1:0]  c_DROP_MAX   = '1;

    // Storage is deliberately left unreset so it maps onto distributed RAM.
    logic [WIDTH-1:0]      r_mem [c_DEPTH];

    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_valid;
    logic                  r_full;
    logic                  r_overflow;
    logic [DROP_BITS-1:0]  r_drop_count;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    cnt_op_e               w_cnt_op;
    logic [DEPTH_LOG2:0]   w_count_next;

    // A full FIFO still accepts a strobe when the head leaves in that cycle.
    assign w_pop  = r_valid && out_ready;
    assign w_push = strobe_in && (!r_full || w_pop);
    assign w_drop = strobe_in && r_full && !w_pop;

    // Select the occupancy change and compute the next count.
    always_comb begin
        w_cnt_op     = CNT_HOLD;
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_cnt_op = CNT_INC;
        end else if (w_pop && !w_push) begin
            w_cnt_op = CNT_DEC;
        end
        case (w_cnt_op)
            CNT_INC: w_count_next = r_count + c_CNT_ONE;
            CNT_DEC: w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Write the incoming word at the tail on every accepted strobe.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and the flags derived from the next occupancy,
    // so out_valid and full come straight from flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
            r_full  <= (w_count_next == c_FULL_COUNT);
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop in the same
    // cycle as a clear takes precedence and restarts the count at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow) begin
                r_drop_count <= c_DROP_ONE;
            end else if (r_drop_count != c_DROP_MAX) begin
                r_drop_count <= r_drop_count + c_DROP_ONE;
            end
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign full       = r_full;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule : strobe_fifo
`default_nettype wire

// File: tb/tb_strobe_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_strobe_fifo
//  Description : Self-checking bench for strobe_fifo (depth 4, 2-bit drop
//                counter). Vector table plus hand-written corner sequences;
//                output words are checked against a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_strobe_fifo;

    localparam int WIDTH      = 8;
    localparam int DEPTH_LOG2 = 2;
    localparam int DROP_BITS  = 2;
    localparam int NVEC       = 22;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  strobe_in;
    logic [WIDTH-1:0]      data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  overflow;
    logic [DROP_BITS-1:0]  drop_count;
    logic                  clear_overflow;

    strobe_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DROP_BITS  (DROP_BITS)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .strobe_in      (strobe_in),
        .data_in        (data_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .count          (count),
        .full           (full),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic [7:0] d;
        logic       r;
        logic       c;
        int         cnt;
        logic       v;
        logic       f;
        logic       o;
        int         dc;
    } vec_t;

    vec_t       tbl [NVEC];
    logic [7:0] sb_q [$];
    int         checks = 0;
    int         errors = 0;
    int         m_count = 0;
    int         pops = 0;
    logic [7:0] last_pop = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check any output word against the
    // scoreboard mid-cycle, update the occupancy model, then step past the edge.
    task automatic cycle(input logic s, input logic [7:0] d, input logic r, input logic c);
        logic m_pop;
        logic m_push;
        strobe_in      = s;
        data_in        = d;
        out_ready      = r;
        clear_overflow = c;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got word %0h expected none", out_data);
            end else begin
                last_pop = sb_q.pop_front();
                chk("pop_data", 32'(out_data), 32'(last_pop));
                pops++;
            end
        end
        m_pop  = (m_count != 0) && r;
        m_push = s && ((m_count != 4) || m_pop);
        if (m_push) sb_q.push_back(d);
        m_count = m_count + int'(m_push) - int'(m_pop);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        m_count = 0;
        sb_q.delete();
    endtask

    initial begin
        // Basic capture, fill/drop/drain, clear, and simultaneous push+pop when full.
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 0};
        tbl[6]  = '{1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 1};
        tbl[7]  = '{1'b1, 8'h06, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 2};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 2};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b1, 2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 2};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        tbl[14] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0};
        tbl[15] = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0};
        tbl[16] = '{1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 0};
        tbl[17] = '{1'b1, 8'h77, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 0};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};

        reset_n        = 1'b0;
        strobe_in      = 1'b0;
        data_in        = '0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        reset_model();

        for (int i = 0; i < NVEC; i++) begin
            cycle(tbl[i].s, tbl[i].d, tbl[i].r, tbl[i].c);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].f));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(tbl[i].o));
            chk($sformatf("v%0d_drop", i), 32'(drop_count), 32'(tbl[i].dc));
            if (i == 0) chk("v0_data", 32'(out_data), 32'hA5);
        end
        chk("last_drained", 32'(last_pop), 32'h77);

        // Streaming: strobe and ready every cycle, occupancy stays at one.
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0);
            chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_pops", 32'(pops), 32'd20);
        chk("stream_empty", 32'(out_valid), 32'd0);

        // Drop counter saturation, clear, and clear coincident with a drop.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("sat_drop", 32'(drop_count), 32'd3);
        chk("sat_overflow", 32'(overflow), 32'd1);
        chk("sat_count", 32'(count), 32'd4);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_count), 32'd0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1);
        chk("clrdrop_overflow", 32'(overflow), 32'd1);
        chk("clrdrop_drop", 32'(drop_count), 32'd1);

        // Leave three words stored, then reset asynchronously mid-cycle.
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        strobe_in = 1'b0;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_overflow", 32'(overflow), 32'd0);
        chk("async_rst_drop", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        reset_model();

        cycle(1'b1, 8'h5C, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'h5C);
        chk("post_rst_count", 32'(count), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_drained", 32'(count), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_strobe_fifo
`default_nettype wire

// File: doc/strobe_fifo.md
Name: strobe_fifo

Overview:
- Destination-domain consumer of the clock-crossing strobe stage.
- Captures each one-cycle strobe_in pulse and its accompanying data word into a small first-word-fall-through FIFO.
- Presents the words to the downstream USB packet logic with a valid/ready handshake.
- Drops and counts words that arrive while full, so bursts on the source side are never silently corrupted.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 2**DEPTH_LOG2, minimum 1).
- DROP_BITS, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock (destination domain of the strobe crossing).
- reset_n  input  1  asynchronous, active-low reset.
- strobe_in  input  1  one-cycle write pulse from the strobe crossing.
- data_in  input  WIDTH  word sampled when strobe_in is high.
- out_valid  output  1  FIFO non-empty; out_data is meaningful.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  WIDTH  head-of-FIFO word.
- count  output  DEPTH_LOG2+1  number of stored words, 0..depth.
- full  output  1  count == depth.
- overflow  output  1  sticky: at least one strobe was dropped.
- drop_count  output  DROP_BITS  saturating count of dropped strobes.
- clear_overflow  input  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - rd_ptr, wr_ptr and count = 0; out_valid = 0; full = 0; overflow = 0; drop_count = 0.
  - Storage array is not reset.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally from depth-1 to 0. count is a separate DEPTH_LOG2+1-bit register.
- pop = out_valid && out_ready.
- push = strobe_in && (!full || pop). A push into a full FIFO is accepted when a pop occurs in the same cycle.
- Write path:
  - On push, mem[wr_ptr] <= data_in and wr_ptr increments.
  - Latency: strobe at edge N gives out_valid high after edge N (visible in cycle N+1) if the FIFO was empty.
- Read path:
  - out_data = mem[rd_ptr], combinational from registered storage (FWFT).
  - On pop, rd_ptr increments.
  - out_data is don't-care while out_valid = 0.
- count update:
  - push only: +1.
  - pop only: -1.
  - Both: unchanged.
  - out_valid = (count != 0); full = (count == depth). Both are derived from count and are glitch-free registered values.
- Empty with strobe_in and out_ready both high: no pop (out_valid is low). Push occurs, count becomes 1.
- Drop (strobe_in && full && !pop):
  - No write; overflow <= 1.
  - drop_count increments, saturating at 2**DROP_BITS-1.
- clear_overflow:
  - Sets overflow to 0 and drop_count to 0 next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_count = 1.
- out_ready high while out_valid is low has no effect.
- strobe_in asserted on consecutive cycles is legal; each cycle is an independent write.
- Reset mid-operation: all stored words are discarded and out_valid drops immediately (asynchronously).

Decomposition:
- Shared package: none required. The only constant is DEPTH = 1 << DEPTH_LOG2, a localparam.
- No sub-module. Pointer and count logic are inline, and the storage array is inferred as distributed RAM.

Test Plan:
- Reset, then single strobe with data_in=0xA5, out_ready=0 -> next cycle out_valid=1, out_data=0xA5, count=1. Then out_ready=1 for one cycle -> out_valid=0, count=0.
- DEPTH_LOG2=2, out_ready=0, 6 strobes with data 0x01..0x06 -> count=4, full=1, overflow=1, drop_count=2. Drain yields 0x01..0x04 in order.
- Full FIFO (4 words), strobe_in with data 0x77 and out_ready=1 in the same cycle -> no drop, count stays 4, overflow stays 0. Last word drained is 0x77.
- Continuous strobes with out_ready=1 for 20 cycles, data 0..19 -> every word out exactly once, in order. count never exceeds 1 and pointers wrap cleanly past 3.
- drop_count saturation with DROP_BITS=2: 5 drops -> drop_count=3. clear_overflow with no drop -> 0/0. clear_overflow coincident with a drop -> overflow=1, drop_count=1.
- reset_n asserted while 3 words are stored -> out_valid=0 and count=0 without waiting for a clock edge. First strobe after release reads back its own data, not stale words.
